// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ burst producers, the round-robin arbiter and the FIFO write port.
// The slave modport is the arbiter's view; the master modport is the producers/FIFO environment.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_wr_en;
    // The full flag travels with the bundle so the arbiter sees both sides of the write path.
    logic                          fifo_full;
    logic                          grant_active;
    logic [ID_WIDTH-1:0]           grant_id;

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  fifo_full,
        output req_ready,
        output fifo_wr_data,
        output fifo_wr_en,
        output grant_active,
        output grant_id
    );

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output fifo_full,
        input  req_ready,
        input  fifo_wr_data,
        input  fifo_wr_en,
        input  grant_active,
        input  grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ valid/ready/last producers.
// A grant is locked for one burst (ended by last or by MAX_BURST beats); data passes straight through.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input logic              clk,
    input logic              rst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q;
    logic [ID_W-1:0]   grant_id_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]  beat_cnt_q;

    logic [NUM_REQ-1:0]    rot_valid;
    logic                  pick_found;
    logic [ID_W:0]         pick_sum;
    logic [ID_W-1:0]       pick_id;
    logic                  g_valid;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  in_burst;
    logic                  xfer;
    logic                  burst_end;
    logic [ID_W-1:0]       rr_next;

    // Rotate the valid vector so bit 0 is the requester at rr_ptr, then take the lowest set bit.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
        rot_valid  = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);
        pick_found = 1'b0;
        pick_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && rot_valid[k]) begin
                pick_found = 1'b1;
                pick_sum   = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            end
        end
        if (pick_sum >= (ID_W+1)'(NUM_REQ)) begin
            pick_sum = pick_sum - (ID_W+1)'(NUM_REQ);
        end
        pick_id = pick_sum[ID_W-1:0];
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                g_valid = bus.req_valid[i];
                g_last  = bus.req_last[i];
                g_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign in_burst  = (state_q == BURST);
    assign xfer      = in_burst && g_valid && !bus.fifo_full;
    assign burst_end = xfer && (g_last || (beat_cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST)));
    assign rr_next   = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = in_burst && (grant_id_q == ID_W'(i)) && !bus.fifo_full;
        end
    end

    // Zero-latency pass-through; data is zeroed only outside a grant so reset forces it low.
    assign bus.fifo_wr_en   = xfer;
    assign bus.fifo_wr_data = in_burst ? g_data : '0;
    assign bus.grant_active = in_burst;
    assign bus.grant_id     = grant_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q    <= BURST;
                        grant_id_q <= pick_id;
                        beat_cnt_q <= '0;
                    end
                end
                BURST: begin
                    // Grant stays locked through valid gaps and full stalls; only a transfer moves it.
                    if (xfer) begin
                        if (burst_end) begin
                            state_q    <= IDLE;
                            rr_ptr_q   <= rr_next;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
